// File: rtl/uart_rx_if.sv
// uart_rx output bundle: received byte, strobes and status.
// The receiver drives it through master; consumers read through slave.
interface uart_rx_if;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    modport master (
        output data_out,
        output data_valid,
        output frame_err,
        output busy
    );

    modport slave (
        input data_out,
        input data_valid,
        input frame_err,
        input busy
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 2-FF synchroniser, mid-bit sampling,
// one-cycle valid/frame-error strobes and break hold-off.
module uart_rx #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     rx,
    uart_rx_if.master bus
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    dout_q, dout_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic [1:0]    sync_q;
    logic          rx_s;

    assign rx_s = sync_q[1];

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], rx};
    end

    // Frame state, counters, shift register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // Next-state logic: half-bit start qualification, then one sample
    // per bit period; the strobe fires as the stop bit is sampled.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_M1) begin
                    shift_d[idx_q] = rx_s;
                    cnt_d          = '0;
                    if (idx_q == 3'd7) state_d = S_STOP;
                    else               idx_d   = idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        dout_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_BREAK: begin
                cnt_d = '0;
                if (rx_s) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.data_out   = dout_q;
    assign bus.data_valid = valid_q;
    assign bus.frame_err  = ferr_q;
    assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed frames against a frame-level
// model of expected bytes, frame errors and strobe latency.
module tb_uart_rx;

    localparam int CPB = 8;
    localparam int LAT = CPB / 2 + 9 * CPB;

    logic clk = 1'b0;
    logic rst_n;
    logic drv_rx;
    logic tx_line;
    logic loop_en;
    logic rx;

    assign rx = loop_en ? tx_line : drv_rx;

    uart_rx_if bus ();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         err;
        logic [7:0] data;
        int         lat;
    } ev_t;

    typedef struct {
        bit         err;
        logic [7:0] data;
    } exp_t;

    ev_t  obs_q[$];
    exp_t exp_q[$];

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         rise_cyc = 0;
    int         viol     = 0;
    bit         busy_prev  = 1'b0;
    bit         pulse_prev = 1'b0;
    logic [7:0] model_last = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor: records strobes with latency from busy rise and
    // counts any overlap or back-to-back strobe cycles.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_prev  = 1'b0;
            pulse_prev = 1'b0;
        end else begin
            if (bus.busy === 1'b1 && !busy_prev) rise_cyc = cyc;
            busy_prev = (bus.busy === 1'b1);
            if (bus.data_valid === 1'b1 || bus.frame_err === 1'b1)
                obs_q.push_back('{bus.frame_err === 1'b1, bus.data_out,
                                  cyc - rise_cyc});
            if ((bus.data_valid === 1'b1 && bus.frame_err === 1'b1) ||
                ((bus.data_valid === 1'b1 || bus.frame_err === 1'b1) &&
                 pulse_prev))
                viol++;
            pulse_prev = (bus.data_valid === 1'b1 || bus.frame_err === 1'b1);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        drv_rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            drv_rx = b[i];
            idle(CPB);
        end
        drv_rx = stop_ok;
        idle(CPB);
        drv_rx = 1'b1;
        exp_q.push_back('{!stop_ok, b});
        if (stop_ok) model_last = b;
    endtask

    task automatic tx_stage_send(input logic [7:0] b);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            tx_line = frame[0];
            frame   = frame >> 1;
            idle(CPB);
        end
        tx_line = 1'b1;
        exp_q.push_back('{1'b0, b});
        model_last = b;
    endtask

    task automatic wait_events(input int n, input int budget);
        int k;
        k = 0;
        while (obs_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic clear_q;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset;
        rst_n  = 1'b1;
        drv_rx = 1'b1;
        #2 rst_n = 1'b0;
        idle(5);
        n_checks++;
        if (bus.data_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data_out: got %02h expected 00", bus.data_out);
        end
        n_checks++;
        if (bus.data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_data_valid: got %b expected 0", bus.data_valid);
        end
        n_checks++;
        if (bus.frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_frame_err: got %b expected 0", bus.frame_err);
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b expected 0", bus.busy);
        end
        rst_n = 1'b1;
        idle(4);
    endtask

    task automatic test_single_frame;
        clear_q();
        send_frame(8'h55, 1'b1);
        idle(10);
        n_checks++;
        if (bus.data_out !== model_last) begin
            n_fail++;
            $display("FAIL single_hold0: got %02h expected %02h",
                     bus.data_out, model_last);
        end
        send_frame(8'hA3, 1'b1);
        idle(10);
        wait_events(exp_q.size(), 200);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL single_count: got %0d expected %0d",
                     obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].err !== exp_q[i].err ||
                obs_q[i].data !== exp_q[i].data) begin
                n_fail++;
                $display("FAIL single_ev%0d: got err=%0b data=%02h expected err=%0b data=%02h",
                         i, obs_q[i].err, obs_q[i].data,
                         exp_q[i].err, exp_q[i].data);
            end
            n_checks++;
            if (obs_q[i].lat !== LAT) begin
                n_fail++;
                $display("FAIL single_lat%0d: got %0d expected %0d",
                         i, obs_q[i].lat, LAT);
            end
        end
    endtask

    task automatic test_back_to_back;
        clear_q();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h81, 1'b1);
        loop_en = 1'b1;
        tx_stage_send(8'h3C);
        idle(10);
        loop_en = 1'b0;
        wait_events(exp_q.size(), 200);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d expected %0d",
                     obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].err !== exp_q[i].err ||
                obs_q[i].data !== exp_q[i].data) begin
                n_fail++;
                $display("FAIL b2b_ev%0d: got err=%0b data=%02h expected err=%0b data=%02h",
                         i, obs_q[i].err, obs_q[i].data,
                         exp_q[i].err, exp_q[i].data);
            end
        end
    endtask

    task automatic test_false_start;
        clear_q();
        drv_rx = 1'b0;
        idle(2);
        drv_rx = 1'b1;
        idle(20);
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL false_busy: got %b expected 0", bus.busy);
        end
        n_checks++;
        if (obs_q.size() !== 0) begin
            n_fail++;
            $display("FAIL false_pulses: got %0d expected 0", obs_q.size());
        end
        n_checks++;
        if (bus.data_out !== model_last) begin
            n_fail++;
            $display("FAIL false_data: got %02h expected %02h",
                     bus.data_out, model_last);
        end
    endtask

    task automatic test_frame_error;
        clear_q();
        send_frame(8'h12, 1'b0);
        drv_rx = 1'b0;
        idle(40);
        n_checks++;
        if (obs_q.size() !== 1 || (obs_q.size() > 0 && obs_q[0].err !== 1'b1)) begin
            n_fail++;
            $display("FAIL ferr_hold: got %0d events expected 1 frame error",
                     obs_q.size());
        end
        n_checks++;
        if (bus.data_out !== model_last) begin
            n_fail++;
            $display("FAIL ferr_data_kept: got %02h expected %02h",
                     bus.data_out, model_last);
        end
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ferr_break_busy: got %b expected 1", bus.busy);
        end
        drv_rx = 1'b1;
        idle(16);
        send_frame(8'h34, 1'b1);
        idle(10);
        wait_events(exp_q.size(), 200);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL ferr_count: got %0d expected %0d",
                     obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].err !== exp_q[i].err ||
                (!exp_q[i].err && obs_q[i].data !== exp_q[i].data)) begin
                n_fail++;
                $display("FAIL ferr_ev%0d: got err=%0b data=%02h expected err=%0b data=%02h",
                         i, obs_q[i].err, obs_q[i].data,
                         exp_q[i].err, exp_q[i].data);
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        clear_q();
        fork
            send_frame(8'h5A, 1'b1);
            begin
                idle(5 * CPB + CPB / 2);
                rst_n = 1'b0;
            end
        join
        exp_q.delete();
        model_last = 8'h00;
        idle(4);
        rst_n = 1'b1;
        idle(4);
        n_checks++;
        if (bus.data_out !== 8'h00 || bus.busy !== 1'b0 ||
            bus.data_valid !== 1'b0 || bus.frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got data=%02h busy=%b dv=%b fe=%b expected 00 0 0 0",
                     bus.data_out, bus.busy, bus.data_valid, bus.frame_err);
        end
        send_frame(8'hC7, 1'b1);
        idle(10);
        wait_events(exp_q.size(), 200);
        n_checks++;
        if (obs_q.size() !== 1) begin
            n_fail++;
            $display("FAIL midrst_count: got %0d expected 1", obs_q.size());
        end
        n_checks++;
        if (bus.data_out !== model_last) begin
            n_fail++;
            $display("FAIL midrst_data: got %02h expected %02h",
                     bus.data_out, model_last);
        end
    endtask

    task automatic test_random;
        logic [7:0] b;
        bit         ok;
        int         gap;
        clear_q();
        for (int n = 0; n < 24; n++) begin
            b   = 8'($urandom_range(0, 255));
            ok  = ($urandom_range(0, 4) != 0);
            gap = ok ? $urandom_range(0, 8) : 4 + $urandom_range(0, 8);
            send_frame(b, ok);
            idle(gap);
        end
        idle(20);
        wait_events(exp_q.size(), 200);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_count: got %0d expected %0d",
                     obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].err !== exp_q[i].err ||
                (!exp_q[i].err && obs_q[i].data !== exp_q[i].data)) begin
                n_fail++;
                $display("FAIL rand_ev%0d: got err=%0b data=%02h expected err=%0b data=%02h",
                         i, obs_q[i].err, obs_q[i].data,
                         exp_q[i].err, exp_q[i].data);
            end
            n_checks++;
            if (obs_q[i].lat !== LAT) begin
                n_fail++;
                $display("FAIL rand_lat%0d: got %0d expected %0d",
                         i, obs_q[i].lat, LAT);
            end
        end
        n_checks++;
        if (bus.data_out !== model_last) begin
            n_fail++;
            $display("FAIL rand_data_hold: got %02h expected %02h",
                     bus.data_out, model_last);
        end
    endtask

    task automatic test_exclusive;
        n_checks++;
        if (viol !== 0) begin
            n_fail++;
            $display("FAIL pulse_exclusive: got %0d violations expected 0", viol);
        end
    endtask

    initial begin
        rst_n   = 1'b1;
        drv_rx  = 1'b1;
        tx_line = 1'b1;
        loop_en = 1'b0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_false_start();
        test_frame_error();
        test_reset_mid_frame();
        test_random();
        test_exclusive();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
